// File: rtl/cmp_share_ctrl_pkg.sv
// Shared definitions for the comparator-sharing controller: FSM encoding,
// default sizing and the combinational helpers used by the top and the core.
package cmp_share_ctrl_pkg;

    // Controller states; the encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Default sizing of the controller.
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 3;

    // The rotating search is written for the largest supported requester
    // count; smaller configurations zero-extend their request vector.
    localparam int RR_MAX = 8;

    // Rotating first-one search: returns the index of the first set bit of
    // req when scanning ptr, ptr+1, ... with wrap modulo nreq. Returns 0 when
    // no bit is set (the caller only uses the result when req is non-zero).
    function automatic int rr_first(input logic [RR_MAX-1:0] req,
                                    input int               ptr,
                                    input int               nreq);
        logic       found;
        int         idx;
        int         win;
        logic [2:0] idx3;
        found = 1'b0;
        win   = 0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx  = (ptr + i) % nreq;
            idx3 = idx[2:0];
            if ((i < nreq) && !found && req[idx3]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Full-adder cell: sum output.
    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    // Full-adder cell: carry output.
    function automatic logic fa_cout(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/cmp_share_ctrl_cmp_core.sv
// Shared unsigned magnitude comparator. Computes x + ~y + 1 with a ripple
// chain of full-adder cells; the carry-out tells x >= y, and the sum bits
// (x - y) tell equality, so no separate XOR tree is needed.
module cmp_core
    import cmp_share_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_ny;
    logic             w_nonzero;

    // Two's-complement subtraction: invert y and inject the +1 as carry-in.
    assign w_ny       = ~i_y;
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign w_sum[g]     = fa_sum (i_x[g], w_ny[g], w_carry[g]);
        assign w_carry[g+1] = fa_cout(i_x[g], w_ny[g], w_carry[g]);
    end

    // Difference is zero only when x == y; carry-out clear means a borrow.
    assign w_nonzero = |w_sum;
    assign o_eq      = w_carry[WIDTH] & ~w_nonzero;
    assign o_gt      = w_carry[WIDTH] &  w_nonzero;
    assign o_lt      = ~w_carry[WIDTH];

endmodule

// File: rtl/cmp_share_ctrl.sv
// Round-robin controller sharing one magnitude comparator between NREQ
// requesters. IDLE arbitrates and latches the winner's operands, CMP lets
// the comparator settle on the latched operands and registers the flags,
// RESP presents the tagged result for one cycle.
module cmp_share_ctrl
    import cmp_share_ctrl_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] x_in,
    input  logic [NREQ*WIDTH-1:0] y_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  xgty,
    output logic                  xlty,
    output logic                  xeqy
);

    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW-1:0]  ZERO_ID  = IDW'(0);
    localparam logic [IDW-1:0]  ONE_ID   = IDW'(1);
    localparam logic [NREQ-1:0] ZERO_GNT = NREQ'(0);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [WIDTH-1:0] ZERO_OP = WIDTH'(0);

    // State and registered outputs.
    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [NREQ-1:0]  r_gnt;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    // Arbitration and operand-selection nets.
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_x_sel;
    logic [WIDTH-1:0] w_y_sel;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;

    // Winner of the rotating search starting at the round-robin pointer.
    assign w_win = IDW'(rr_first(RR_MAX'(req), int'(r_ptr), NREQ));

    // Pointer moves just past the winner so it gets lowest priority next time.
    assign w_ptr_nxt = (w_win == LAST_ID) ? ZERO_ID : (w_win + ONE_ID);

    // AND-OR multiplexer picking the winner's operand slices.
    always_comb begin
        w_x_sel = ZERO_OP;
        w_y_sel = ZERO_OP;
        for (int i = 0; i < NREQ; i++) begin
            w_x_sel = w_x_sel | (x_in[i*WIDTH +: WIDTH] & {WIDTH{w_win == IDW'(i)}});
            w_y_sel = w_y_sel | (y_in[i*WIDTH +: WIDTH] & {WIDTH{w_win == IDW'(i)}});
        end
    end

    // The single shared comparator always looks at the latched operands, so
    // requester operand changes after capture cannot disturb the result.
    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .i_x  (r_x),
        .i_y  (r_y),
        .o_gt (w_gt),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    // Controller FSM: arbitration, operand capture, result registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ZERO_ID;
            r_id        <= ZERO_ID;
            r_x         <= ZERO_OP;
            r_y         <= ZERO_OP;
            r_gnt       <= ZERO_GNT;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= ZERO_ID;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (|req) begin
                        r_x     <= w_x_sel;
                        r_y     <= w_y_sel;
                        r_gnt   <= ONE_HOT0 << w_win;
                        r_id    <= w_win;
                        r_ptr   <= w_ptr_nxt;
                        r_busy  <= 1'b1;
                        r_state <= ST_CMP;
                    end else begin
                        r_gnt   <= ZERO_GNT;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    r_gt        <= w_gt;
                    r_lt        <= w_lt;
                    r_eq        <= w_eq;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_gnt       <= ZERO_GNT;
                    r_busy      <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_gnt       <= ZERO_GNT;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_gnt       <= ZERO_GNT;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign xgty      = r_gt;
    assign xlty      = r_lt;
    assign xeqy      = r_eq;

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl (NREQ=4, WIDTH=3): table-driven single
// transactions followed by hand-written multi-cycle sequences.
module tb_cmp_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] x_in;
    logic [11:0] y_in;
    logic [3:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        xgty;
    logic        xlty;
    logic        xeqy;

    int n_chk  = 0;
    int n_fail = 0;

    // One transaction: request, operands, expected grant/id/flags {gt,lt,eq}.
    typedef struct {
        logic [3:0]  rq;
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  egnt;
        logic [1:0]  eid;
        logic [2:0]  eflags;
    } vec_t;

    vec_t vecs [7];

    cmp_share_ctrl #(
        .NREQ  (4),
        .WIDTH (3),
        .IDW   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .xgty      (xgty),
        .xlty      (xlty),
        .xeqy      (xeqy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        int          ng;
        int          last_rv;
        logic [3:0]  rr_exp [5];
        logic [2:0]  ef;

        // Pointer walk: 0 ->1 ->3 ->0 ->1 ->2 ->0 ->2
        vecs[0] = '{4'b0001, 12'h005, 12'h003, 4'b0001, 2'd0, 3'b100}; // x0=5 y0=3
        vecs[1] = '{4'b0100, 12'h180, 12'h180, 4'b0100, 2'd2, 3'b001}; // x2=6 y2=6
        vecs[2] = '{4'b1000, 12'h000, 12'hE00, 4'b1000, 2'd3, 3'b010}; // x3=0 y3=7
        vecs[3] = '{4'b0011, 12'h03A, 12'h004, 4'b0001, 2'd0, 3'b010}; // x0=2 y0=4
        vecs[4] = '{4'b0011, 12'h027, 12'h020, 4'b0010, 2'd1, 3'b001}; // x1=4 y1=4
        vecs[5] = '{4'b1001, 12'hE00, 12'hC01, 4'b1000, 2'd3, 3'b100}; // x3=7 y3=6, wrap
        vecs[6] = '{4'b0110, 12'h1C8, 12'h010, 4'b0010, 2'd1, 3'b010}; // x1=1 y1=2

        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        rst  = 1'b1;
        req  = 4'b0000;
        x_in = 12'h000;
        y_in = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id",    32'(rsp_id), 32'h0);
        chk("rst_flags", 32'({xgty, xlty, xeqy}), 32'h0);
        rst = 1'b0;

        // Table-driven single transactions.
        for (int k = 0; k < 7; k++) begin
            v    = vecs[k];
            req  = v.rq;
            x_in = v.x;
            y_in = v.y;
            tick();
            chk($sformatf("v%0d_gnt", k),   32'(gnt), 32'(v.egnt));
            chk($sformatf("v%0d_busy", k),  32'(busy), 32'h1);
            chk($sformatf("v%0d_nval", k),  32'(rsp_valid), 32'h0);
            req = 4'b0000;
            tick();
            chk($sformatf("v%0d_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("v%0d_id", k),    32'(rsp_id), 32'(v.eid));
            chk($sformatf("v%0d_flags", k), 32'({xgty, xlty, xeqy}), 32'(v.eflags));
            chk($sformatf("v%0d_gnt0", k),  32'(gnt), 32'h0);
            tick();
            chk($sformatf("v%0d_idle_val", k),  32'(rsp_valid), 32'h0);
            chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'h0);
            chk($sformatf("v%0d_hold", k),      32'({xgty, xlty, xeqy}), 32'(v.eflags));
        end

        // Operand stability: x1 changes during CMP, result uses captured value.
        req  = 4'b0010;
        x_in = 12'h038;
        y_in = 12'h008;
        tick();
        chk("stab_gnt", 32'(gnt), 32'h2);
        req  = 4'b0000;
        x_in = 12'h000;
        tick();
        chk("stab_valid", 32'(rsp_valid), 32'h1);
        chk("stab_id",    32'(rsp_id), 32'h1);
        chk("stab_flags", 32'({xgty, xlty, xeqy}), 32'h4);
        tick();

        // Reset asserted during CMP aborts the operation.
        req  = 4'b0100;
        x_in = 12'h040;
        y_in = 12'h080;
        tick();
        chk("rmid_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        #1;
        chk("rmid_gnt0",  32'(gnt), 32'h0);
        chk("rmid_busy0", 32'(busy), 32'h0);
        chk("rmid_val0",  32'(rsp_valid), 32'h0);
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rmid_noval", 32'(rsp_valid), 32'h0);
            chk("rmid_idle",  32'(busy), 32'h0);
        end

        // Round robin with all requesters; each drops req during its grant.
        // The first grant going to 0 shows the pointer was reset.
        ng      = 0;
        last_rv = -1;
        req     = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            tick();
            if ((gnt != 4'b0000) && (ng < 5)) begin
                chk($sformatf("rr_gnt%0d", ng), 32'(gnt), 32'(rr_exp[ng]));
                ng++;
            end
            if (rsp_valid) begin
                if (last_rv >= 0) begin
                    chk("rr_spacing", 32'(c - last_rv), 32'd3);
                end
                last_rv = c;
            end
            req = ~gnt;
        end
        chk("rr_count", 32'(ng), 32'd5);
        req = 4'b0000;
        repeat (3) tick();

        // Exhaustive compare through requester 0.
        for (int xv = 0; xv < 8; xv++) begin
            for (int yv = 0; yv < 8; yv++) begin
                req  = 4'b0001;
                x_in = 12'(xv);
                y_in = 12'(yv);
                tick();
                req = 4'b0000;
                tick();
                if (xv > yv)      ef = 3'b100;
                else if (xv < yv) ef = 3'b010;
                else              ef = 3'b001;
                chk($sformatf("ex_%0d_%0d", xv, yv), 32'({xgty, xlty, xeqy}), 32'(ef));
                chk("ex_onehot", 32'({1'b0, xgty} + {1'b0, xlty} + {1'b0, xeqy}), 32'd1);
                chk("ex_valid",  32'(rsp_valid), 32'h1);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_share_ctrl.md
Name: cmp_share_ctrl

Overview:
- Round-robin scheduler that shares one WIDTH-bit magnitude comparator between NREQ requesters.
- Each requester presents an operand pair and a request. The controller grants one requester, latches its operands, runs the shared comparator, and returns a tagged one-cycle result.
- Sits between requesting datapath blocks and the single adder-based comparator instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 3, operand width in bits.
- IDW, 2, width of the requester id; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; bit i belongs to requester i.
- x_in  in  NREQ*WIDTH  operand x of requester i in bits [i*WIDTH +: WIDTH].
- y_in  in  NREQ*WIDTH  operand y of requester i, same packing as x_in.
- gnt  out  NREQ  one-hot grant, one-cycle pulse.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  IDW  index of the requester the result belongs to.
- xgty  out  1  x > y, unsigned.
- xlty  out  1  x < y, unsigned.
- xeqy  out  1  x == y.

Behaviour:
- Reset: state=IDLE, ptr=0, operand registers=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, xgty=xlty=xeqy=0.
- Reset is asynchronous: any operation in progress is aborted and no rsp_valid is produced for it.
- FSM states: IDLE, CMP, RESP.
- IDLE with req==0: stay in IDLE; all outputs hold 0 except the result fields (rsp_id, xgty, xlty, xeqy), which hold their last values.
- IDLE with req!=0:
  - Winner w = first set bit of req, scanning ptr, ptr+1, … with wrap modulo NREQ.
  - On the edge: capture x_in/y_in slice w into the operand registers, gnt <= one-hot(w), id register <= w, ptr <= (w+1) mod NREQ, state <= CMP.
- CMP:
  - gnt is high for exactly this cycle; busy=1.
  - The comparator evaluates the latched operands combinationally.
  - On the edge: register xgty/xlty/xeqy, rsp_id <= id, rsp_valid <= 1, gnt <= 0, state <= RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle; busy=1.
  - On the edge: rsp_valid <= 0, state <= IDLE.
  - Result fields hold until the next RESP.
- Latency: req sampled at edge k → gnt high in cycle k+1 → rsp_valid high in cycle k+2. Throughput is one compare per 3 cycles under continuous requests.
- Requester handshake:
  - Hold req and operands stable until gnt is observed.
  - Deassert req no later than the edge that ends the gnt cycle.
  - req is ignored in CMP and RESP. A req still high on return to IDLE is treated as a new request.
- Operand changes after capture have no effect on the result.
- Result flags: exactly one of xgty/xlty/xeqy is 1 while rsp_valid=1.
- Arithmetic: unsigned compare, computed as x + ~y + 1 over WIDTH bits.
  - carry-out=1 and sum==0 → equal.
  - carry-out=1 and sum!=0 → greater.
  - carry-out=0 → less.
  - Equality must use the sum bits, not a separate XOR tree.
- Fairness: a requester held continuously high is granted within NREQ grants.
- Pointer wrap: a grant to NREQ-1 sets ptr=0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, CMP=2'd1, RESP=2'd2), default NREQ/WIDTH, and a helper function for the rotating first-one search.
- One natural sub-module, cmp_core:
  - Purely combinational WIDTH-bit comparator (x, y → gt, lt, eq).
  - Built from the team's full-adder/half-adder cells using the x + ~y + 1 formulation.
  - Instantiated once inside cmp_share_ctrl.
- The arbiter and FSM stay in the top module.

Test Plan:
- Single request, req=4'b0001, x0=5, y0=3 → gnt=0001 one cycle later; next cycle rsp_valid=1, rsp_id=0, xgty=1, xlty=0, xeqy=0.
- Equality and less:
  - req=4'b0100, x2=6, y2=6 → rsp_id=2, xeqy=1.
  - Then req=4'b1000, x3=0, y3=7 → rsp_id=3, xlty=1.
- Round robin: req=4'b1111 held high with requesters dropping req after their gnt and re-raising it → grant order 0,1,2,3,0.
  - ptr wraps after 3.
  - rsp_valid pulses spaced exactly 3 cycles apart.
- Operand stability: x1=7, y1=1 captured at grant; change x1 to 0 during CMP → result still xgty=1, rsp_id=1.
- Reset mid-operation: assert rst during CMP → gnt, busy and rsp_valid drop to 0 immediately; no rsp_valid after release; state IDLE, ptr=0.
- Exhaustive: all 64 (x,y) pairs for WIDTH=3 through requester 0 → flags match a behavioural compare, with exactly one flag set for every pair.
